// File: rtl/timer_sched_pkg.sv
// Shared FSM states, timer register map and bus-cycle helper for the tick scheduler.
package timer_sched_pkg;

  typedef enum logic [2:0] {INIT, IDLE, CLEAR, SETTLE, DISPATCH, RESTART} state_t;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;
  localparam logic [2:0] SNAPL   = 3'd4;
  localparam logic [2:0] SNAPH   = 3'd5;

  localparam logic [15:0] CTRL_ITO = 16'h0001;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_bus_t;

  localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'h0000};

  function automatic tmr_bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    tmr_bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b0;
    b.addr    = addr;
    b.data    = data;
    return b;
  endfunction

endpackage

// File: rtl/timer_tick_channel.sv
// One software tick channel: divides the base tick by div+1 while enabled.
module timer_tick_channel #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             resync,
  input  logic             dispatch,
  output logic             tick
);

  logic             en_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic             tick_reg;

  // A configuration write overrides a dispatch landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_reg   <= 1'b0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (cfg_load) begin
        en_reg  <= cfg_en;
        div_reg <= cfg_div;
        cnt_reg <= '0;
      end else if (resync) begin
        cnt_reg <= '0;
      end else if (dispatch && en_reg) begin
        if (cnt_reg == div_reg) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/timer_tick_scheduler.sv
// Sole Avalon-MM master of the interval timer: arms ITO, services each timeout and
// fans the base tick out to NUM_CH divided channels.
module timer_tick_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sw_restart,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [31:0]       tick_count,
  output logic              busy
);

  state_t      state_reg;
  tmr_bus_t    bus_reg;
  logic [31:0] tick_count_reg;
  logic        restart_pend_reg;
  logic        ito_sent_reg;
  logic        suppress_reg;

  logic restart_take;
  logic dispatch;
  logic [NUM_CH-1:0] tick_vec;

  assign restart_take = (state_reg == IDLE) && (restart_pend_reg || sw_restart);
  assign dispatch     = (state_reg == DISPATCH);

  // Bus cycles are registered on entry to the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= INIT;
      bus_reg          <= BUS_IDLE;
      tick_count_reg   <= '0;
      restart_pend_reg <= 1'b0;
      ito_sent_reg     <= 1'b0;
      suppress_reg     <= 1'b0;
    end else begin
      bus_reg <= BUS_IDLE;
      if (sw_restart && state_reg != IDLE) restart_pend_reg <= 1'b1;
      case (state_reg)
        INIT: begin
          if (!ito_sent_reg) begin
            bus_reg      <= bus_write(CONTROL, CTRL_ITO);
            ito_sent_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          if (restart_take) begin
            state_reg        <= RESTART;
            bus_reg          <= bus_write(PERIODL, 16'h0000);
            restart_pend_reg <= 1'b0;
            tick_count_reg   <= '0;
            suppress_reg     <= 1'b1;
          end else if (tmr_irq) begin
            state_reg    <= CLEAR;
            bus_reg      <= bus_write(STATUS, 16'h0000);
            suppress_reg <= 1'b0;
          end
        end
        RESTART: begin
          state_reg <= CLEAR;
          bus_reg   <= bus_write(STATUS, 16'h0000);
        end
        CLEAR:  state_reg <= SETTLE;
        SETTLE: state_reg <= suppress_reg ? IDLE : DISPATCH;
        DISPATCH: begin
          tick_count_reg <= tick_count_reg + 32'd1;
          state_reg      <= IDLE;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    timer_tick_channel #(.DIV_W(DIV_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cfg_load (cfg_wr && (cfg_ch == CH_W'(gi))),
      .cfg_en   (cfg_en),
      .cfg_div  (cfg_div),
      .resync   (restart_take),
      .dispatch (dispatch),
      .tick     (tick_vec[gi])
    );
  end

  assign tmr_address    = bus_reg.addr;
  assign tmr_chipselect = bus_reg.cs;
  assign tmr_write_n    = bus_reg.write_n;
  assign tmr_writedata  = bus_reg.data;
  assign ch_tick        = tick_vec;
  assign tick_count     = tick_count_reg;
  assign busy           = (state_reg != IDLE);

endmodule
